// File: rtl/ps2_action_decoder.sv
// PS/2 scan-code to fighter-action decoder.
// This module tracks the E0 (extended) and F0 (break) prefixes and keeps a
// six-bit held-key bitmap for each player. For each player it also runs a
// timed attack window and presents a prioritised action code.
module ps2_action_decoder #(
  parameter int NUM_PLAYERS   = 2,
  parameter int ACTION_W      = 3,
  parameter int ATTACK_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      code,
  input  logic                            code_valid,
  output logic [NUM_PLAYERS*ACTION_W-1:0] action,
  output logic [NUM_PLAYERS*6-1:0]        held,
  output logic [NUM_PLAYERS-1:0]          attack_start
);

  // Prefix FSM states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  // Bit positions inside each player's held group
  localparam int BIT_LEFT  = 0;
  localparam int BIT_RIGHT = 1;
  localparam int BIT_UP    = 2;
  localparam int BIT_DOWN  = 3;
  localparam int BIT_PUNCH = 4;
  localparam int BIT_KICK  = 5;

  // Action codes. The value 7 is reserved and is never produced.
  localparam logic [ACTION_W-1:0] ACT_IDLE   = ACTION_W'(0);
  localparam logic [ACTION_W-1:0] ACT_LEFT   = ACTION_W'(1);
  localparam logic [ACTION_W-1:0] ACT_RIGHT  = ACTION_W'(2);
  localparam logic [ACTION_W-1:0] ACT_JUMP   = ACTION_W'(3);
  localparam logic [ACTION_W-1:0] ACT_CROUCH = ACTION_W'(4);
  localparam logic [ACTION_W-1:0] ACT_PUNCH  = ACTION_W'(5);
  localparam logic [ACTION_W-1:0] ACT_KICK   = ACTION_W'(6);

  // The attack counter is 16 bits wide, so it covers ATTACK_CYCLES values from 1 to 65535.
  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ATTACK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The function returns a one-hot held bit for player p when code c arrives with extended flag e.
  // For a given (c, e) pair, at most one player can receive a nonzero result.
  function automatic logic [5:0] f_hit(input logic [7:0] c, input logic e, input int p);
    logic [5:0] h;
    h = 6'd0;
    if (p == 0) begin
      if (!e) begin
        case (c)
          8'h1C:   h[BIT_LEFT]  = 1'b1;
          8'h23:   h[BIT_RIGHT] = 1'b1;
          8'h1D:   h[BIT_UP]    = 1'b1;
          8'h1B:   h[BIT_DOWN]  = 1'b1;
          8'h3B:   h[BIT_PUNCH] = 1'b1;
          8'h42:   h[BIT_KICK]  = 1'b1;
          default: h = 6'd0;
        endcase
      end
    end else begin
      if (e) begin
        case (c)
          8'h6B:   h[BIT_LEFT]  = 1'b1;
          8'h74:   h[BIT_RIGHT] = 1'b1;
          8'h75:   h[BIT_UP]    = 1'b1;
          8'h72:   h[BIT_DOWN]  = 1'b1;
          default: h = 6'd0;
        endcase
      end else begin
        case (c)
          8'h69:   h[BIT_PUNCH] = 1'b1;
          8'h72:   h[BIT_KICK]  = 1'b1;
          default: h = 6'd0;
        endcase
      end
    end
    return h;
  endfunction

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_is_rst_code;
  logic       w_clr;
  logic       w_term;
  logic       w_ext;
  logic       w_brk;
  logic       w_make;
  logic       w_break;

  assign w_is_e0       = (code == 8'hE0);
  assign w_is_f0       = (code == 8'hF0);
  // The codes AA, FC, FF and 00 are keyboard self-test and error responses.
  // When one of them arrives, all key state is discarded.
  assign w_is_rst_code = (code == 8'hAA) || (code == 8'hFC) ||
                         (code == 8'hFF) || (code == 8'h00);
  assign w_clr         = code_valid && w_is_rst_code;
  // A terminal byte is any byte that is not a prefix and not a reset code.
  // It completes a make or a break, even when the code is unmapped.
  assign w_term        = code_valid && !w_is_rst_code && !w_is_e0 && !w_is_f0;
  assign w_ext         = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_brk         = (r_state == S_BRK) || (r_state == S_EXT_BRK);
  assign w_make        = w_term && !w_brk;
  assign w_break       = w_term && w_brk;

  // Prefix FSM next-state logic. The state advances only on a valid byte.
  always_comb begin
    w_state_next = r_state;
    if (code_valid) begin
      if (w_is_rst_code) begin
        w_state_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_is_e0)      w_state_next = S_EXT;
            else if (w_is_f0) w_state_next = S_BRK;
            else              w_state_next = S_IDLE;
          end
          S_EXT: begin
            if (w_is_f0)      w_state_next = S_EXT_BRK;
            else if (w_is_e0) w_state_next = S_EXT;
            else              w_state_next = S_IDLE;
          end
          S_BRK: begin
            if (w_is_e0)      w_state_next = S_EXT_BRK;
            else if (w_is_f0) w_state_next = S_BRK;
            else              w_state_next = S_IDLE;
          end
          S_EXT_BRK: begin
            if (w_is_e0 || w_is_f0) w_state_next = S_EXT_BRK;
            else                    w_state_next = S_IDLE;
          end
          default: w_state_next = S_IDLE;
        endcase
      end
    end
  end

  // Prefix FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [5:0]          w_hit;
      logic                w_open;
      logic [ACTION_W-1:0] w_action;
      logic [5:0]          r_held;
      logic [CNT_W-1:0]    r_cnt;
      logic                r_kick;
      logic                r_start;

      assign w_hit  = f_hit(code, w_ext, gi);
      // A window opens only on a fresh attack make that arrives while no window is running.
      assign w_open = w_make && (w_hit[BIT_PUNCH] || w_hit[BIT_KICK]) &&
                      ((r_held & w_hit) == 6'd0) && (r_cnt == '0);

      // Held bitmap update: a make sets the key bit and a break clears it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_held <= 6'd0;
        end else if (w_clr) begin
          r_held <= 6'd0;
        end else if (w_make) begin
          r_held <= r_held | w_hit;
        end else if (w_break) begin
          r_held <= r_held & ~w_hit;
        end
      end

      // Attack window: the counter loads on open, latches the attack type and
      // then counts down to zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_kick  <= 1'b0;
          r_start <= 1'b0;
        end else begin
          r_start <= w_open;
          if (w_clr) begin
            r_cnt <= '0;
          end else if (w_open) begin
            r_cnt  <= CNT_LOAD;
            r_kick <= w_hit[BIT_KICK];
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
      end

      // Prioritised action decode from registered state. A running attack
      // takes precedence, then jump, crouch and walking.
      always_comb begin
        w_action = ACT_IDLE;
        if (r_cnt != '0) begin
          w_action = r_kick ? ACT_KICK : ACT_PUNCH;
        end else if (r_held[BIT_UP]) begin
          w_action = ACT_JUMP;
        end else if (r_held[BIT_DOWN]) begin
          w_action = ACT_CROUCH;
        end else if (r_held[BIT_LEFT] ^ r_held[BIT_RIGHT]) begin
          w_action = r_held[BIT_LEFT] ? ACT_LEFT : ACT_RIGHT;
        end
      end

      assign action[gi*ACTION_W +: ACTION_W] = w_action;
      assign held[gi*6 +: 6]                 = r_held;
      assign attack_start[gi]                = r_start;
    end
  endgenerate

endmodule

// File: tb/tb_ps2_action_decoder.sv
// Directed testbench for ps2_action_decoder. It drives two instances that share one stimulus stream:
// one instance uses the default 16-cycle attack window and the other uses a 4-cycle window.
module tb_ps2_action_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;

  logic [5:0]  act16, act4;
  logic [11:0] held16, held4;
  logic [1:0]  st16, st4;

  int total = 0;
  int bad   = 0;

  // Per-cycle monitor counters: m_a counts cycles with action4 P1 equal to 5, m_s counts start4[0] pulses,
  // m_b counts cycles with action16 P2 equal to 6, and m_t counts start16[1] pulses.
  int m_a, m_s, m_b, m_t;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  ps2_action_decoder #(.NUM_PLAYERS(2), .ACTION_W(3), .ATTACK_CYCLES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .action(act16), .held(held16), .attack_start(st16)
  );

  ps2_action_decoder #(.NUM_PLAYERS(2), .ACTION_W(3), .ATTACK_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .action(act4), .held(held4), .attack_start(st4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample the outputs at the falling edge, then drive this cycle's byte.
  task automatic step(input logic v, input logic [7:0] c);
    @(negedge clk);
    if (mon_en) begin
      if (act4[2:0] == 3'd5)  m_a++;
      if (st4[0])             m_s++;
      if (act16[5:3] == 3'd6) m_b++;
      if (st16[1])            m_t++;
    end
    code       = c;
    code_valid = v;
  endtask

  // Send one byte. On return the bench is at the falling edge of cycle n+1.
  task automatic send(input logic [7:0] c);
    step(1'b1, c);
    step(1'b0, 8'h00);
    $display("tx code=%02h held16=%03h act16=%02h st16=%0b held4=%03h act4=%02h",
             c, held16, act16, st16, held4, act4);
  endtask

  task automatic mon_clear();
    m_a = 0; m_s = 0; m_b = 0; m_t = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_held16", 32'(held16), 32'h000);
    chk("rst_act16",  32'(act16),  32'h00);
    chk("rst_st16",   32'(st16),   32'h0);
    chk("rst_held4",  32'(held4),  32'h000);
    rst_n = 1'b1;

    // P1 left make/break, and a byte with code_valid low is ignored
    send(8'h1C);
    chk("t1_held",    32'(held16),     32'h001);
    chk("t1_act_p1",  32'(act16[2:0]), 32'd1);
    chk("t1_act_p2",  32'(act16[5:3]), 32'd0);
    send(8'hF0);
    chk("t1_pfx_held", 32'(held16), 32'h001);
    send(8'h1C);
    chk("t1_brk_held", 32'(held16),     32'h000);
    chk("t1_brk_act",  32'(act16[2:0]), 32'd0);
    step(1'b0, 8'h23);
    step(1'b0, 8'h00);
    chk("t1_novalid", 32'(held16), 32'h000);

    // Left+right cancels, up takes priority
    send(8'h1C); send(8'h23);
    chk("t2_lr_held", 32'(held16),     32'h003);
    chk("t2_lr_act",  32'(act16[2:0]), 32'd0);
    send(8'h1D);
    chk("t2_up_held", 32'(held16),     32'h007);
    chk("t2_up_act",  32'(act16[2:0]), 32'd3);
    send(8'hF0); send(8'h1D);
    chk("t2_upbrk_held", 32'(held16),     32'h003);
    chk("t2_upbrk_act",  32'(act16[2:0]), 32'd0);
    send(8'hF0); send(8'h1C);
    chk("t2_right_act", 32'(act16[2:0]), 32'd2);
    send(8'hF0); send(8'h23);
    chk("t2_clr_held", 32'(held16), 32'h000);

    // E0 72 is P2 down, plain 72 is P2 kick with a 16-cycle window
    send(8'hE0); send(8'h72);
    chk("t3_down_held", 32'(held16),     32'h200);
    chk("t3_down_act",  32'(act16[5:3]), 32'd4);
    chk("t3_p1_act",    32'(act16[2:0]), 32'd0);
    mon_clear();
    step(1'b1, 8'h72);
    repeat (20) step(1'b0, 8'h00);
    mon_en = 1'b0;
    chk("t3_kick_cycles", 32'(m_b), 32'd16);
    chk("t3_kick_starts", 32'(m_t), 32'd1);
    chk("t3_after_act",   32'(act16[5:3]), 32'd4);
    chk("t3_kick_held",   32'(held16),     32'hA00);
    send(8'hF0); send(8'h72);
    chk("t3_kbrk_held", 32'(held16), 32'h200);
    send(8'hE0); send(8'hF0); send(8'h72);
    chk("t3_dbrk_held", 32'(held16), 32'h000);

    // 4-cycle window: make, typematic repeat at +2, then break
    mon_clear();
    step(1'b1, 8'h3B);
    step(1'b0, 8'h00);
    step(1'b1, 8'h3B);
    step(1'b0, 8'h00);
    chk("t4_punch_held", 32'(held4[4]), 32'd1);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h3B);
    repeat (8) step(1'b0, 8'h00);
    mon_en = 1'b0;
    chk("t4_punch_cycles", 32'(m_a), 32'd4);
    chk("t4_punch_starts", 32'(m_s), 32'd1);
    chk("t4_brk_held",     32'(held4),     32'h000);
    chk("t4_after_act",    32'(act4[2:0]), 32'd0);
    repeat (10) step(1'b0, 8'h00);

    // Extended break and repeated E0 prefix
    send(8'hE0); send(8'h75);
    chk("t5_up_held", 32'(held16),     32'h100);
    chk("t5_up_act",  32'(act16[5:3]), 32'd3);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t5_upbrk_held", 32'(held16), 32'h000);
    send(8'hE0); send(8'hE0); send(8'h6B);
    chk("t5_left_held", 32'(held16),     32'h040);
    chk("t5_left_act",  32'(act16[5:3]), 32'd1);
    send(8'h1C);
    chk("t5_idle_after", 32'(held16), 32'h041);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("t5_clr_held", 32'(held16), 32'h000);

    // A reset code in the middle of a sequence clears held bits and counters
    send(8'h1C); send(8'hE0); send(8'h74); send(8'h42);
    chk("t6_kick_start", 32'(st16[0]),    32'd1);
    chk("t6_multi_held", 32'(held16),     32'h0A1);
    chk("t6_kick_act",   32'(act16[2:0]), 32'd6);
    chk("t6_p2_act",     32'(act16[5:3]), 32'd2);
    send(8'hF0); send(8'hAA);
    chk("t6_aa_held16", 32'(held16), 32'h000);
    chk("t6_aa_act16",  32'(act16),  32'h00);
    chk("t6_aa_held4",  32'(held4),  32'h000);
    send(8'h1C);
    chk("t6_make_after", 32'(held16), 32'h001);
    send(8'h3B);
    chk("t6_reopen_start", 32'(st16[0]),    32'd1);
    chk("t6_reopen_act",   32'(act16[2:0]), 32'd5);

    // Asynchronous reset during an attack with a break prefix pending
    send(8'hF0);
    chk("t7_pre_act", 32'(act16[2:0]), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_act16",  32'(act16),  32'h00);
    chk("t7_rst_held16", 32'(held16), 32'h000);
    chk("t7_rst_st16",   32'(st16),   32'h0);
    chk("t7_rst_act4",   32'(act4),   32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h1C);
    chk("t7_make_after", 32'(held16), 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_action_decoder.md
Name: ps2_action_decoder

Overview:
- Converts the PS/2 scan-code byte stream from the keyboard receiver into per-player fighter actions.
- Tracks make/break (F0) and extended (E0) prefixes, and keeps a held-key bitmap for each player.
- Emits a prioritised action code per player, with timed attack windows.
- Sits between the PS/2 receiver and the fighter state/animation logic.

Parameters:
- NUM_PLAYERS, 2, number of players decoded; legal values are 1 and 2. With 1, player-2 keys are ignored.
- ACTION_W, 3, width of each player's action code; must be ≥3.
- ATTACK_CYCLES, 16, number of cycles an attack action is presented after its make code; legal range is 1..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- code  in  8  scan-code byte from the receiver.
- code_valid  in  1  one-cycle strobe; `code` is sampled only when this is high.
- action  out  NUM_PLAYERS*ACTION_W  per-player action code; player p occupies bits [p*ACTION_W +: ACTION_W].
- held  out  NUM_PLAYERS*6  per-player held bitmap {kick,punch,down,up,right,left}; left is the LSB of each 6-bit group.
- attack_start  out  NUM_PLAYERS  one-cycle pulse per player when an attack window opens.

Behaviour:
- Reset, applied asynchronously:
  - FSM goes to IDLE.
  - `held` = 0, all attack counters = 0, `attack_start` = 0, `action` = 0.
  - Reset mid-sequence discards any pending prefix.
- Key map:
  - P1 keys are non-extended: left 1C, right 23, up 1D, down 1B, punch 3B, kick 42.
  - P2 directions are extended: E0 6B left, E0 74 right, E0 75 up, E0 72 down.
  - P2 attacks are non-extended: punch 69, kick 72.
  - 72 without E0 is P2 kick; E0 72 is P2 down.
  - Unmapped codes are ignored, but they still terminate the current prefix sequence.
- Prefix FSM (advances only on code_valid):
  - IDLE: E0 → EXT; F0 → BRK; other → make(code, ext=0), stay IDLE.
  - EXT: F0 → EXT_BRK; E0 → stay EXT; other → make(code, ext=1), then IDLE.
  - BRK: F0 → stay BRK; E0 → EXT_BRK; other → break(code, ext=0), then IDLE.
  - EXT_BRK: F0/E0 → stay EXT_BRK; other → break(code, ext=1), then IDLE.
  - Codes AA, FC, FF, 00 in any state: clear all `held` bits and all attack counters, then go to IDLE. These codes are never mapped.
- Make/break effects:
  - make sets the mapped `held` bit; break clears it.
  - Typematic repeats of a make leave `held` unchanged.
  - A break of a key that is not held has no effect.
- Attack rules:
  - An attack opens on a punch/kick make only when three conditions all hold: the key's `held` bit was 0 before this code, the player's counter is 0, and the player exists.
  - When it opens: load counter = ATTACK_CYCLES, latch the attack type, and pulse attack_start[p] in the next cycle.
  - Makes arriving during an open window are recorded in `held` but never re-trigger the attack.
  - The counter decrements by 1 each cycle while nonzero, saturating at 0.
  - A break of the attack key does not cut the window short.
- Action encoding: 0 idle, 1 left, 2 right, 3 jump, 4 crouch, 5 punch, 6 kick; 7 is reserved and never driven.
- Action priority, per player:
  - counter ≠ 0 → latched attack;
  - else up → 3;
  - else down → 4;
  - else left XOR right → 1 or 2;
  - else (neither, or both left and right) → 0.
- Timing:
  - `held`, the counters and `attack_start` are registered.
  - `action` is decoded combinationally from registered state.
  - code_valid in cycle n → `held` and `action` reflect the code in cycle n+1.
  - The attack window presents the attack for exactly ATTACK_CYCLES cycles: n+1 through n+ATTACK_CYCLES.
- Concurrency: both players update independently. The same code byte never affects both players, because the key map is disjoint once the ext flag is included.
- Bytes arriving with code_valid low are ignored; the FSM holds its state.

Test Plan:
- Reset then 1C (P1 left make) → held[0]=1 at n+1 and action P1=1; later F0,1C → held[0]=0 and action P1=0.
- P1 holds 1C+23 → action P1=0; then make 1D → action P1=3; break 1D → action P1=0.
- E0,72 → P2 held down bit set, action P2=4, P1 unchanged; plain 72 → P2 kick: attack_start[1] pulses for 1 cycle and action P2=6 for 16 cycles, then returns to 4.
- ATTACK_CYCLES=4: 3B, then 3B again at +2 cycles (typematic), then F0,3B → exactly one attack_start[0], action P1=5 for exactly 4 cycles, held punch bit cleared after the break.
- E0 F0 75 with P2 up held → P2 up bit cleared; E0,E0,6B → P2 left set, one extended make only.
- Mid-sequence F0 then AA with several keys held → all `held`=0, counters=0, FSM in IDLE (next 1C is treated as a make); async rst_n pulse mid-attack → all outputs 0 immediately.
